// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared sizes, index type and hazard helper for the register scoreboard.
package reg_scoreboard_pkg;

    localparam int NREG    = 32;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 2;
    localparam int STALL_W = 16;

    typedef logic [IDX_W-1:0]   reg_idx_t;
    typedef logic [CNT_W-1:0]   sb_cnt_t;
    typedef logic [STALL_W-1:0] stall_t;

    localparam sb_cnt_t CNT_MAX   = '1;
    localparam stall_t  STALL_MAX = '1;

    // A pending source stops being a hazard when its last outstanding write lands this cycle.
    function automatic logic src_hazard(
        input logic     flag,
        input reg_idx_t idx,
        input logic     pending,
        input logic     last_one,
        input logic     retiring
    );
        return flag && (idx != '0) && pending && !(retiring && last_one);
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: per-register count of in-flight writes, bumped at issue and drained at writeback.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W_P = CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [CNT_W_P-1:0] cnt_o,
    output logic               busy_o,
    output logic               at_max_o,
    output logic               is_one_o,
    output logic               underflow_o
);

    localparam logic [CNT_W_P-1:0] MAX = '1;
    localparam logic [CNT_W_P-1:0] ONE = CNT_W_P'(1);

    logic [CNT_W_P-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (inc_i == dec_i) ? cnt_q
              : inc_i            ? ((cnt_q == MAX) ? cnt_q : cnt_q + ONE)
              :                    ((cnt_q == '0)  ? cnt_q : cnt_q - ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o       = cnt_q;
    assign busy_o      = cnt_q != '0;
    assign at_max_o    = cnt_q == MAX;
    assign is_one_o    = cnt_q == ONE;
    assign underflow_o = dec_i && !inc_i && (cnt_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes and gates ID issue on RAW/WAW hazards.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_valid,
    input  logic               issue_rs1_flag,
    input  logic [IDX_W-1:0]   issue_rs1,
    input  logic               issue_rs2_flag,
    input  logic [IDX_W-1:0]   issue_rs2,
    input  logic               issue_rd_flag,
    input  logic [IDX_W-1:0]   issue_rd,
    output logic               issue_ready,
    input  logic               wb_flag,
    input  logic [IDX_W-1:0]   wb_address,
    output logic [NREG-1:0]    busy_mask,
    output logic [STALL_W-1:0] stall_count,
    output logic               underflow_err
);

    sb_cnt_t         cnt [NREG];
    logic [NREG-1:0] busy, at_max, is_one, uflow;
    logic            rs1_haz, rs2_haz, rd_haz, fire;
    stall_t          stall_q, stall_d;
    logic            err_q, err_d;

    // x0 is hardwired: no counter, never pending.
    assign cnt[0]    = '0;
    assign busy[0]   = 1'b0;
    assign at_max[0] = 1'b0;
    assign is_one[0] = 1'b0;
    assign uflow[0]  = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        logic inc, dec;
        assign inc = fire && (issue_rd == IDX_W'(i));
        assign dec = wb_flag && (wb_address == IDX_W'(i));
        sb_counter #(.CNT_W_P(CNT_W)) u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (inc),
            .dec_i       (dec),
            .cnt_o       (cnt[i]),
            .busy_o      (busy[i]),
            .at_max_o    (at_max[i]),
            .is_one_o    (is_one[i]),
            .underflow_o (uflow[i])
        );
    end

    always_comb begin
        rs1_haz = src_hazard(issue_rs1_flag, issue_rs1, cnt[issue_rs1] != '0, is_one[issue_rs1],
                             wb_flag && (wb_address == issue_rs1));
        rs2_haz = src_hazard(issue_rs2_flag, issue_rs2, cnt[issue_rs2] != '0, is_one[issue_rs2],
                             wb_flag && (wb_address == issue_rs2));
        rd_haz  = issue_rd_flag && (issue_rd != '0) && at_max[issue_rd]
                  && !(wb_flag && (wb_address == issue_rd));
        issue_ready = rst_n && !rs1_haz && !rs2_haz && !rd_haz;
        fire    = issue_valid && issue_ready && issue_rd_flag && (issue_rd != '0);
        stall_d = (issue_valid && !issue_ready && stall_q != STALL_MAX) ? stall_q + 1'b1 : stall_q;
        err_d   = err_q || (|uflow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign busy_mask     = busy;
    assign stall_count   = stall_q;
    assign underflow_err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and random stimulus against a per-register pending-count model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0, issue_rs1_flag = 1'b0, issue_rs2_flag = 1'b0, issue_rd_flag = 1'b0;
    logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
    logic        issue_ready;
    logic        wb_flag = 1'b0;
    logic [4:0]  wb_address = '0;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;
    logic        underflow_err;

    int errors = 0, checks = 0;
    int m_cnt [32];
    int m_stall;
    bit m_err;

    reg_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .issue_rs1_flag(issue_rs1_flag), .issue_rs1(issue_rs1),
        .issue_rs2_flag(issue_rs2_flag), .issue_rs2(issue_rs2),
        .issue_rd_flag(issue_rd_flag), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_flag(wb_flag), .wb_address(wb_address), .busy_mask(busy_mask),
        .stall_count(stall_count), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ret(input int r);
        return wb_flag && int'(wb_address) == r && r != 0;
    endfunction

    function automatic bit m_src_haz(input bit f, input int r);
        return f && r != 0 && m_cnt[r] > 0 && !(m_ret(r) && m_cnt[r] == 1);
    endfunction

    function automatic bit m_ready();
        int d = int'(issue_rd);
        bit hd = issue_rd_flag && d != 0 && m_cnt[d] == 3 && !m_ret(d);
        return !(m_src_haz(issue_rs1_flag, int'(issue_rs1)) || m_src_haz(issue_rs2_flag, int'(issue_rs2)) || hd);
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int r = 1; r < 32; r++) b[r] = m_cnt[r] > 0;
        return b;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_stall = 0;
        m_err = 0;
    endtask

    task automatic drive(input bit v, input bit f1, input int r1, input bit f2, input int r2,
                         input bit fd, input int rd, input bit wf, input int wa);
        issue_valid = v; issue_rs1_flag = f1; issue_rs1 = 5'(r1); issue_rs2_flag = f2; issue_rs2 = 5'(r2);
        issue_rd_flag = fd; issue_rd = 5'(rd); wb_flag = wf; wb_address = 5'(wa);
    endtask

    // Inputs are applied with clk high, just after a rising edge.
    task automatic step(input bit do_chk, input string tag);
        bit rdy, fire;
        #1;
        rdy = m_ready();
        if (do_chk) chk({tag, ".ready"}, {31'b0, issue_ready}, {31'b0, rdy});
        fire = issue_valid && rdy && issue_rd_flag && issue_rd != 0;
        for (int r = 1; r < 32; r++) begin
            bit inc = fire && int'(issue_rd) == r;
            bit dec = m_ret(r);
            if (inc && !dec) m_cnt[r]++;
            else if (dec && !inc) begin
                if (m_cnt[r] == 0) m_err = 1;
                else m_cnt[r]--;
            end
        end
        if (issue_valid && !rdy && m_stall < 65535) m_stall++;
        @(posedge clk);
        #1;
        if (do_chk) begin
            chk({tag, ".busy"}, busy_mask, m_busy());
            chk({tag, ".stall"}, {16'b0, stall_count}, 32'(m_stall));
            chk({tag, ".err"}, {31'b0, underflow_err}, {31'b0, m_err});
        end
    endtask

    // Assert reset away from any edge, check the immediate effect, release after the next edge.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        drive(1, 1, 2, 1, 4, 0, 0, 0, 0);
        #1;
        m_clear();
        chk({tag, ".rst_busy"}, busy_mask, 32'h0);
        chk({tag, ".rst_ready"}, {31'b0, issue_ready}, 32'h0);
        chk({tag, ".rst_stall"}, {16'b0, stall_count}, 32'h0);
        chk({tag, ".rst_err"}, {31'b0, underflow_err}, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        m_clear();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset.ready", {31'b0, issue_ready}, 32'h0);
        chk("reset.busy", busy_mask, 32'h0);
        chk("reset.stall", {16'b0, stall_count}, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);  step(1, "raw.issue5");
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, "raw.stall");
        drive(1, 1, 5, 0, 0, 0, 0, 1, 5);  step(1, "raw.bypass");

        drive(1, 0, 0, 0, 0, 1, 7, 0, 0);  step(1, "byp.issue7");
        drive(1, 0, 0, 1, 7, 0, 0, 1, 7);  step(1, "byp.rs2_wb7");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  step(1, "byp.idle");

        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        for (int k = 0; k < 3; k++) step(1, "waw.fill3");
        step(1, "waw.full");
        drive(1, 0, 0, 0, 0, 1, 3, 1, 3);  step(1, "waw.swap");

        drive(1, 1, 0, 1, 0, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(1, "x0");

        drive(0, 0, 0, 0, 0, 0, 0, 1, 9);  step(1, "uflow.wb9");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  step(1, "uflow.sticky");

        drive(1, 0, 0, 0, 0, 1, 2, 0, 0);  step(1, "rst.issue2");
        drive(1, 0, 0, 0, 0, 1, 4, 0, 0);  step(1, "rst.issue4");
        mid_reset("mid");
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0);  step(1, "rst.after");

        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                  $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7));
            step(1, "rand");
            if (k == 300) mid_reset("rand");
        end

        mid_reset("sat");
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);  step(1, "sat.issue5");
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 65540; k++) step(0, "sat");
        step(1, "sat.hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
